// File: rtl/fp_addsub_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fp_addsub_param
// Description : Multi-cycle parametrised floating-point adder/subtractor with
//               RNE/truncate rounding, special-value handling and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic         rnd,
    input  logic [W-1:0] data_a,
    input  logic [W-1:0] data_b,
    output logic         busy,
    output logic         ready,
    output logic [W-1:0] data_o,
    output logic [3:0]   flags
);

    localparam int c_FW = MAN_W + 4;            // significand + guard/round/sticky
    localparam int c_XW = EXP_W + 2;            // exponent with carry headroom
    localparam int c_LW = $clog2(c_FW + 1);
    localparam logic [EXP_W-1:0] c_EXP_MAX = '1;
    localparam logic [W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADDSUB = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic             r_go;
    logic [W-1:0]     r_a, r_b;
    logic             r_op, r_rnd;
    logic             r_spec;
    logic [W-1:0]     r_spec_data;
    logic [3:0]       r_spec_flags;
    logic             r_sa, r_sb;
    logic [EXP_W-1:0] r_ea, r_eb;
    logic [MAN_W:0]   r_ma, r_mb;
    logic [c_XW-1:0]  r_exp;
    logic [c_FW-1:0]  r_fl, r_fs, r_nf;
    logic [c_FW:0]    r_sum;
    logic             r_sign, r_sub;
    logic             r_ready;
    logic [W-1:0]     r_data_o;
    logic [3:0]       r_flags;

    // The accepting edge only captures operands; unpacking starts one edge later.
    logic w_accept;
    assign w_accept = (r_state == S_IDLE) && !r_go && start;

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (r_go) w_next = S_UNPACK;
            S_UNPACK: w_next = S_ALIGN;
            S_ALIGN:  w_next = S_ADDSUB;
            S_ADDSUB: w_next = S_NORM;
            S_NORM:   w_next = S_ROUND;
            S_ROUND:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Unpack and classify
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic             w_spec;
    logic [W-1:0]     w_spec_data;
    logic [3:0]       w_spec_flags;

    assign w_sa     = r_a[W-1];
    assign w_sb     = r_b[W-1] ^ r_op;
    assign w_ea     = r_a[W-2:MAN_W];
    assign w_eb     = r_b[W-2:MAN_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_EXP_MAX) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_EXP_MAX) && (w_fb == '0);
    assign w_a_nan  = (w_ea == c_EXP_MAX) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_EXP_MAX) && (w_fb != '0);

    always_comb begin
        w_spec       = 1'b1;
        w_spec_data  = '0;
        w_spec_flags = 4'b0000;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb))) begin
            w_spec_data  = c_QNAN;
            w_spec_flags = 4'b1000;
        end else if (w_a_inf) begin
            w_spec_data = {w_sa, c_EXP_MAX, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_spec_data = {w_sb, c_EXP_MAX, {MAN_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_spec_data = {w_sa & w_sb, {(W-1){1'b0}}};
        end else if (w_a_zero) begin
            w_spec_data = {w_sb, w_eb, w_fb};
        end else if (w_b_zero) begin
            w_spec_data = r_a;
        end else begin
            w_spec = 1'b0;
        end
    end

    // Align: larger magnitude first, smaller shifted right with sticky
    logic             w_a_big, w_sl;
    logic [EXP_W-1:0] w_el, w_es, w_diff;
    logic [MAN_W:0]   w_ml, w_ms;
    logic [31:0]      w_shamt;
    logic [c_FW-1:0]  w_fsh, w_al;

    always_comb begin
        w_a_big = {r_ea, r_ma} >= {r_eb, r_mb};
        if (w_a_big) begin
            w_el = r_ea; w_es = r_eb; w_ml = r_ma; w_ms = r_mb; w_sl = r_sa;
        end else begin
            w_el = r_eb; w_es = r_ea; w_ml = r_mb; w_ms = r_ma; w_sl = r_sb;
        end
        w_diff  = w_el - w_es;
        w_shamt = 32'(w_diff);
        w_fsh   = {w_ms, 3'b000};
        if (w_shamt >= 32'(MAN_W + 3))
            w_al = c_FW'(1);
        else
            w_al = (w_fsh >> w_shamt) | c_FW'(|(w_fsh & ~({c_FW{1'b1}} << w_shamt)));
    end

    // Normalise: carry shifts right, otherwise leading-zero shift left
    logic [c_LW-1:0] w_lzc;
    logic [c_FW-1:0] w_nf;
    logic [c_XW-1:0] w_nexp;
    logic            w_uflow, w_zero;

    always_comb begin
        w_lzc = '0;
        for (int i = 0; i < c_FW; i++)
            if (r_sum[i]) w_lzc = c_LW'(c_FW - 1 - i);
        w_nf    = r_sum[c_FW-1:0] << w_lzc;
        w_nexp  = r_exp - c_XW'(w_lzc);
        w_uflow = 32'(r_exp) <= 32'(w_lzc);
        w_zero  = (r_sum == '0);
        if (r_sum[c_FW]) begin
            w_nf    = {r_sum[c_FW:2], r_sum[1] | r_sum[0]};
            w_nexp  = r_exp + c_XW'(1);
            w_uflow = 1'b0;
        end
    end

    // Round
    logic [MAN_W:0]   w_mant;
    logic [MAN_W+1:0] w_mr;
    logic [MAN_W-1:0] w_frac;
    logic [c_XW-1:0]  w_rexp;
    logic             w_g, w_r, w_s, w_inc, w_ovf;
    logic [W-1:0]     w_rdata;
    logic [3:0]       w_rflags;

    always_comb begin
        w_mant = r_nf[c_FW-1:3];
        w_g    = r_nf[2];
        w_r    = r_nf[1];
        w_s    = r_nf[0];
        w_inc  = !r_rnd && w_g && (w_r || w_s || w_mant[0]);
        w_mr   = {1'b0, w_mant} + (MAN_W+2)'(w_inc);
        if (w_mr[MAN_W+1]) begin
            w_rexp = r_exp + c_XW'(1);
            w_frac = w_mr[MAN_W:1];
        end else begin
            w_rexp = r_exp;
            w_frac = w_mr[MAN_W-1:0];
        end
        w_ovf = w_rexp >= c_XW'(c_EXP_MAX);
        if (w_ovf) begin
            w_rflags = 4'b0101;
            if (r_rnd) w_rdata = {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            else       w_rdata = {r_sign, c_EXP_MAX, {MAN_W{1'b0}}};
        end else begin
            w_rflags = {3'b000, w_g | w_r | w_s};
            w_rdata  = {r_sign, w_rexp[EXP_W-1:0], w_frac};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_go     <= 1'b0;
            r_ready  <= 1'b0;
            r_data_o <= '0;
            r_flags  <= 4'b0000;
        end else begin
            r_go    <= w_accept;
            r_ready <= 1'b0;
            if (w_accept) begin
                r_a   <= data_a;
                r_b   <= data_b;
                r_op  <= op;
                r_rnd <= rnd;
            end
            case (r_state)
                S_UNPACK: begin
                    r_spec       <= w_spec;
                    r_spec_data  <= w_spec_data;
                    r_spec_flags <= w_spec_flags;
                    r_sa <= w_sa;
                    r_sb <= w_sb;
                    r_ea <= w_ea;
                    r_eb <= w_eb;
                    r_ma <= {1'b1, w_fa};
                    r_mb <= {1'b1, w_fb};
                end
                S_ALIGN: begin
                    r_exp  <= {2'b00, w_el};
                    r_fl   <= {w_ml, 3'b000};
                    r_fs   <= w_al;
                    r_sign <= w_sl;
                    r_sub  <= r_sa ^ r_sb;
                end
                S_ADDSUB: begin
                    if (r_sub) r_sum <= {1'b0, r_fl} - {1'b0, r_fs};
                    else       r_sum <= {1'b0, r_fl} + {1'b0, r_fs};
                end
                S_NORM: begin
                    r_nf  <= w_nf;
                    r_exp <= w_nexp;
                    // Exact cancellation is +0; exponent underflow flushes to signed zero.
                    if (!r_spec && w_zero) begin
                        r_spec       <= 1'b1;
                        r_spec_data  <= '0;
                        r_spec_flags <= 4'b0000;
                    end else if (!r_spec && w_uflow) begin
                        r_spec       <= 1'b1;
                        r_spec_data  <= {r_sign, {(W-1){1'b0}}};
                        r_spec_flags <= 4'b0011;
                    end
                end
                S_ROUND: begin
                    r_ready  <= 1'b1;
                    r_data_o <= r_spec ? r_spec_data  : w_rdata;
                    r_flags  <= r_spec ? r_spec_flags : w_rflags;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign ready  = r_ready;
    assign data_o = r_data_o;
    assign flags  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fp_addsub_param
// Description : Directed self-checking bench for fp_addsub_param (fp32, fp16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, op, rnd;
    logic [31:0] data_a, data_b;
    logic        busy, ready;
    logic [31:0] data_o;
    logic [3:0]  flags;

    logic        h_start, h_op, h_rnd;
    logic [15:0] h_a, h_b;
    logic        h_busy, h_ready;
    logic [15:0] h_data_o;
    logic [3:0]  h_flags;

    int n_cmp = 0;
    int n_err = 0;
    int n_rdy;
    int rdy_at;

    always #5 clk = ~clk;

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clock(clk), .reset(rst), .start(start), .op(op), .rnd(rnd),
        .data_a(data_a), .data_b(data_b), .busy(busy), .ready(ready),
        .data_o(data_o), .flags(flags)
    );

    fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u_half (
        .clock(clk), .reset(rst), .start(h_start), .op(h_op), .rnd(h_rnd),
        .data_a(h_a), .data_b(h_b), .busy(h_busy), .ready(h_ready),
        .data_o(h_data_o), .flags(h_flags)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one fp32 operation and check handshake timing and result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic o, input logic r,
                          input logic [31:0] exp_d, input logic [3:0] exp_f);
        data_a = a; data_b = b; op = o; rnd = r; start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        data_a = $urandom;
        data_b = $urandom;
        op     = ~o;
        rnd    = ~r;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i < 6) begin
                check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
                check_val({tag, "_rdy_early"}, {31'd0, ready}, 32'd0);
            end
        end
        check_val({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check_val({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_data"}, data_o, exp_d);
        check_val({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_f});
    endtask

    task automatic run_half(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic o, input logic [15:0] exp_d, input logic [3:0] exp_f);
        h_a = a; h_b = b; h_op = o; h_rnd = 1'b0; h_start = 1'b1;
        @(posedge clk); #1;
        h_start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 5) check_val({tag, "_busy"}, {31'd0, h_busy}, 32'd1);
        end
        check_val({tag, "_ready"}, {31'd0, h_ready}, 32'd1);
        check_val({tag, "_data"}, {16'd0, h_data_o}, {16'd0, exp_d});
        check_val({tag, "_flags"}, {28'd0, h_flags}, {28'd0, exp_f});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 1'b0; rnd = 1'b0; data_a = '0; data_b = '0;
        h_start = 1'b0; h_op = 1'b0; h_rnd = 1'b0; h_a = '0; h_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_val("rst_busy",  {31'd0, busy},  32'd0);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_data",  data_o, 32'd0);
        check_val("rst_flags", {28'd0, flags}, 32'd0);
        check_val("rst_hdata", {16'd0, h_data_o}, 32'd0);

        run_op("rne",      32'h59FD3D97, 32'h51E5F4BE, 1'b0, 1'b0, 32'h59FD3E7D, 4'b0001);
        run_op("trunc",    32'h59FD3D97, 32'h51E5F4BE, 1'b0, 1'b1, 32'h59FD3E7C, 4'b0001);
        run_op("cancel",   32'h3FC00000, 32'h3FC00000, 1'b1, 1'b0, 32'h00000000, 4'b0000);
        run_op("one_one",  32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 4'b0000);
        run_op("ovf_rne",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 4'b0101);
        run_op("ovf_trn",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 4'b0101);
        run_op("inf_inf",  32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("nan",      32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("sub_norm", 32'h40000000, 32'h3F800000, 1'b1, 1'b0, 32'h3F800000, 4'b0000);
        run_op("zero_x",   32'h00000000, 32'h40490FDB, 1'b1, 1'b0, 32'hC0490FDB, 4'b0000);
        run_op("inf_fin",  32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 32'h7F800000, 4'b0000);
        run_op("pz_nz",    32'h00000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 4'b0000);
        run_op("subnorm",  32'h00000001, 32'h3F800000, 1'b0, 1'b0, 32'h3F800000, 4'b0000);
        run_op("uflow",    32'h00800001, 32'h00800000, 1'b1, 1'b0, 32'h00000000, 4'b0011);
        run_op("neg_add",  32'hBF800000, 32'h3F800000, 1'b1, 1'b0, 32'hC0000000, 4'b0000);
        run_op("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 4'b0001);
        run_op("tie_odd",  32'h3F800001, 32'h33800000, 1'b0, 1'b0, 32'h3F800002, 4'b0001);
        @(posedge clk); #1;
        check_val("ready_1cyc", {31'd0, ready}, 32'd0);

        // Second start while busy must be ignored
        data_a = 32'h3F800000; data_b = 32'h3F800000; op = 1'b0; rnd = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        data_a = 32'h40000000; data_b = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_rdy = 0; rdy_at = 0;
        for (int i = 3; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ready) begin n_rdy++; rdy_at = i; end
        end
        check_val("dbl_count", n_rdy, 32'd1);
        check_val("dbl_at",    rdy_at, 32'd6);
        check_val("dbl_data",  data_o, 32'h40000000);

        // Reset in the middle of an operation
        data_a = 32'h40490FDB; data_b = 32'h3F800000; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mid_rst_busy",  {31'd0, busy},  32'd0);
        check_val("mid_rst_ready", {31'd0, ready}, 32'd0);
        check_val("mid_rst_data",  data_o, 32'd0);
        check_val("mid_rst_flags", {28'd0, flags}, 32'd0);
        n_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready) n_rdy++;
        end
        check_val("mid_rst_noready", n_rdy, 32'd0);
        run_op("post_rst", 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 32'h40000000, 4'b0000);

        run_half("h_add",    16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'b0000);
        run_half("h_cancel", 16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'b0000);
        run_half("h_1p5",    16'h3C00, 16'h3800, 1'b0, 16'h3E00, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_addsub_param.md
Name: fp_addsub_param

Overview:
Parametrised multi-cycle floating-point adder/subtractor. It is the successor to the fixed single-precision add/sub unit that sits behind the start/busy/ready handshake in the top-level datapath. It adds configurable exponent and mantissa widths, selectable rounding mode, IEEE-style special-value handling, and exception flags. It has fixed latency and accepts one operation at a time.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width, hidden bit excluded (>=2)
W, 1+EXP_W+MAN_W, derived total word width (localparam)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  1  0 = data_a + data_b, 1 = data_a - data_b
rnd  in  1  0 = round-to-nearest-even, 1 = truncate (toward zero)
data_a  in  W  operand A {sign, exp, frac}
data_b  in  W  operand B
busy  out  1  operation in progress
ready  out  1  one-cycle pulse: data_o/flags valid
data_o  out  W  result; held until the next accepted start
flags  out  4  {invalid, overflow, underflow, inexact}; held with data_o

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, ready=0, data_o=0, flags=0. Reset mid-operation aborts the operation with no ready pulse.
- FSM: IDLE -> UNPACK -> ALIGN -> ADDSUB -> NORM -> ROUND -> IDLE.
- IDLE with start=1: latch data_a, data_b, op, rnd. busy=1 from the next cycle.
- UNPACK: apply the effective B sign (sign_b ^ op) and classify each operand as zero, normal, inf or NaN. Subnormal inputs (exp=0, frac!=0) are flushed to signed zero.
- ALIGN: swap so |A|>=|B|. Right-shift the smaller significand (hidden bit included) by the exponent difference into a MAN_W+4 bit field holding guard, round and sticky bits. Shifts >= MAN_W+3 leave only sticky set when B is nonzero.
- ADDSUB: add significands if signs are equal, otherwise subtract smaller from larger. The result sign is the sign of the larger operand.
- NORM: on carry-out, shift right 1 and increment the exponent, folding the shifted bit into sticky. Otherwise left-shift by the leading-zero count in one cycle (priority encoder). If the exponent would drop to <=0, the result flushes to signed zero with underflow=1 and inexact=1.
- ROUND:
  - RNE: increment when guard=1 and (round|sticky|lsb)=1.
  - Truncate: never increment.
  - A rounding carry renormalises the result.
  - inexact = guard|round|sticky.
  - If the exponent reaches all-ones: RNE gives signed inf, truncate gives max finite. In both cases overflow=1 and inexact=1.
- Exact zero result from a nonzero subtraction: +0 (both modes).
- Specials (resolved in UNPACK, carried through at the same latency):
  - Any NaN operand -> canonical quiet NaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - inf + (-inf) after the op is applied -> canonical NaN, invalid=1.
  - inf with a finite operand -> that inf, flags=0.
  - Zero with X -> X exactly.
  - (+0)+(-0) -> +0.
- Latency: start accepted at edge k; ready=1 during the cycle after edge k+6, which is the cycle the FSM re-enters IDLE. busy=1 from edge k+1 through edge k+5 and is 0 in the ready cycle. ready lasts exactly 1 cycle.
- start while busy=1 is ignored, with no queueing and no effect on the operation in flight. start in the ready cycle (state IDLE) is accepted normally, giving back-to-back operation.
- Operand inputs may change freely after the accepting edge.
- data_o and flags update only in the ready cycle.

Test Plan:
- EXP_W=8, MAN_W=23, rnd=0, op=0, a=0x59FD3D97, b=0x51E5F4BE -> data_o=0x59FD3E7D, flags=0001, ready 6 cycles after start.
- Same operands with rnd=1 -> data_o=0x59FD3E7C, flags=0001.
- a=0x3FC00000, b=0x3FC00000, op=1 -> data_o=0x00000000, flags=0000. With a=b=0x3F800000, op=0 -> 0x40000000.
- a=b=0x7F7FFFFF, op=0, rnd=0 -> 0x7F800000, flags=0101. With rnd=1 -> 0x7F7FFFFF, flags=0101.
- a=0x7F800000, b=0x7F800000, op=1 -> 0x7FC00000, flags=1000. a=0x7FC00000, b=0x3F800000 -> 0x7FC00000, flags=1000.
- Start pulsed again 2 cycles after the first start, plus a reset asserted mid-operation on a second run:
  - The second start is ignored; a single ready pulse follows.
  - After the reset, busy=0, ready never pulses, and data_o=0.
  - The test is repeated with EXP_W=5, MAN_W=10: 0x3C00+0x3C00 -> 0x4000.
